// File: rtl/regfile_write_arbiter.sv
// Purpose: shares the regfile write port between ALU (A) and load (B) writeback, tracks pending destinations.
// Latency: a grant at edge N drives writeOrder/writeAddr/writeData during cycle N+1; one write per cycle sustained.
// Backpressure: the losing requester sees ready low and must hold valid/addr/data until its ready is high.
module regfile_write_arbiter #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 3,
  parameter int FIXED_PRI = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 aValid,
  input  logic [ADDR_W-1:0]    aAddr,
  input  logic [DATA_W-1:0]    aData,
  output logic                 aReady,
  input  logic                 bValid,
  input  logic [ADDR_W-1:0]    bAddr,
  input  logic [DATA_W-1:0]    bData,
  output logic                 bReady,
  input  logic                 reserveValid,
  input  logic [ADDR_W-1:0]    reserveAddr,
  input  logic [ADDR_W-1:0]    readAddr1,
  input  logic [ADDR_W-1:0]    readAddr2,
  output logic                 hazard1,
  output logic                 hazard2,
  output logic                 writeOrder,
  output logic [ADDR_W-1:0]    writeAddr,
  output logic [DATA_W-1:0]    writeData,
  output logic [2**ADDR_W-1:0] pendingMask
);

  localparam int NREG     = 2**ADDR_W;
  localparam bit FixedPri = (FIXED_PRI != 0);

  // 1 when B won the most recent grant, so A wins the next tie in round-robin mode
  logic            lastGrantB;
  logic            grantA;
  logic            grantB;
  logic [NREG-1:0] setMask;
  logic [NREG-1:0] clearMask;

  // Pick at most one requester; nothing is granted while reset is asserted
  always_comb begin
    grantA = 1'b0;
    grantB = 1'b0;
    if (rst_n) begin
      if (aValid && (!bValid || FixedPri || lastGrantB)) begin
        grantA = 1'b1;
      end else if (bValid) begin
        grantB = 1'b1;
      end
    end
  end

  assign aReady = grantA;
  assign bReady = grantB;

  // Decode the reservation and the write leaving this cycle into per-register masks
  always_comb begin
    setMask   = '0;
    clearMask = '0;
    if (reserveValid) begin
      setMask[reserveAddr] = 1'b1;
    end
    if (writeOrder) begin
      clearMask[writeAddr] = 1'b1;
    end
  end

  // A pending source is safe to read next cycle if its write is on the port right now
  assign hazard1 = pendingMask[readAddr1] & ~(writeOrder & (writeAddr == readAddr1));
  assign hazard2 = pendingMask[readAddr2] & ~(writeOrder & (writeAddr == readAddr2));

  // Register the winning write, the round-robin pointer and the scoreboard
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      writeOrder  <= 1'b0;
      writeAddr   <= '0;
      writeData   <= '0;
      pendingMask <= '0;
      lastGrantB  <= 1'b1;
    end else begin
      writeOrder <= grantA | grantB;
      if (grantA) begin
        writeAddr  <= aAddr;
        writeData  <= aData;
        lastGrantB <= 1'b0;
      end else if (grantB) begin
        writeAddr  <= bAddr;
        writeData  <= bData;
        lastGrantB <= 1'b1;
      end
      // A new reservation outranks a clearing write to the same register
      pendingMask <= (pendingMask & ~clearMask) | setMask;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        aValid, bValid, reserveValid;
  logic [2:0]  aAddr, bAddr, reserveAddr, readAddr1, readAddr2;
  logic [15:0] aData, bData;

  logic        aReady, bReady, hazard1, hazard2, writeOrder;
  logic [2:0]  writeAddr;
  logic [15:0] writeData;
  logic [7:0]  pendingMask;

  logic        fAReady, fBReady, fHazard1, fHazard2, fWriteOrder;
  logic [2:0]  fWriteAddr;
  logic [15:0] fWriteData;
  logic [7:0]  fPendingMask;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DATA_W(16), .ADDR_W(3), .FIXED_PRI(0)) dutR (
    .clk(clk), .rst_n(rst_n),
    .aValid(aValid), .aAddr(aAddr), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bAddr(bAddr), .bData(bData), .bReady(bReady),
    .reserveValid(reserveValid), .reserveAddr(reserveAddr),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .hazard1(hazard1), .hazard2(hazard2),
    .writeOrder(writeOrder), .writeAddr(writeAddr), .writeData(writeData),
    .pendingMask(pendingMask)
  );

  regfile_write_arbiter #(.DATA_W(16), .ADDR_W(3), .FIXED_PRI(1)) dutF (
    .clk(clk), .rst_n(rst_n),
    .aValid(aValid), .aAddr(aAddr), .aData(aData), .aReady(fAReady),
    .bValid(bValid), .bAddr(bAddr), .bData(bData), .bReady(fBReady),
    .reserveValid(reserveValid), .reserveAddr(reserveAddr),
    .readAddr1(readAddr1), .readAddr2(readAddr2),
    .hazard1(fHazard1), .hazard2(fHazard2),
    .writeOrder(fWriteOrder), .writeAddr(fWriteAddr), .writeData(fWriteData),
    .pendingMask(fPendingMask)
  );

  typedef struct {
    logic        rstN;
    logic        aV;
    logic [2:0]  aA;
    logic [15:0] aD;
    logic        bV;
    logic [2:0]  bA;
    logic [15:0] bD;
    logic        rV;
    logic [2:0]  rA;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        eAR;
    logic        eBR;
    logic        eH1;
    logic        eH2;
    logic        eWO;
    logic [2:0]  eWA;
    logic [15:0] eWD;
    logic [7:0]  ePM;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rstN, input logic aV, input logic [2:0] aA, input logic [15:0] aD,
    input logic bV, input logic [2:0] bA, input logic [15:0] bD,
    input logic rV, input logic [2:0] rA, input logic [2:0] r1, input logic [2:0] r2,
    input logic eAR, input logic eBR, input logic eH1, input logic eH2,
    input logic eWO, input logic [2:0] eWA, input logic [15:0] eWD, input logic [7:0] ePM);
    vec_t v;
    v.rstN = rstN; v.aV = aV; v.aA = aA; v.aD = aD;
    v.bV = bV; v.bA = bA; v.bD = bD;
    v.rV = rV; v.rA = rA; v.r1 = r1; v.r2 = r2;
    v.eAR = eAR; v.eBR = eBR; v.eH1 = eH1; v.eH2 = eH2;
    v.eWO = eWO; v.eWA = eWA; v.eWD = eWD; v.ePM = ePM;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rstN, input logic aV, input logic [2:0] aA, input logic [15:0] aD,
                       input logic bV, input logic [2:0] bA, input logic [15:0] bD,
                       input logic rV, input logic [2:0] rA, input logic [2:0] r1, input logic [2:0] r2);
    rst_n = rstN; aValid = aV; aAddr = aA; aData = aD;
    bValid = bV; bAddr = bA; bData = bD;
    reserveValid = rV; reserveAddr = rA; readAddr1 = r1; readAddr2 = r2;
  endtask

  initial begin
    drive(1'b0, 1'b1, 3'd1, 16'h1111, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);

    // Reset with A requesting: no acceptance, outputs cleared
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("rst_aReady", c, aReady, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_writeOrder", c, writeOrder, 1'b0);
    end
    chk("rst_pendingMask", 0, pendingMask, 8'h00);
    chk("rst_writeAddr",   0, writeAddr,   3'd0);
    chk("rst_writeData",   0, writeData,   16'h0000);

    //             rst aV aA  aD        bV bA  bD        rV rA  r1  r2   aR bR h1 h2 wO wA  wD        pm
    // single write
    vecs.push_back(mk(1, 1, 3, 16'h1234, 0, 0, 16'h0000, 0, 0, 0, 0,   1, 0, 0, 0, 1, 3, 16'h1234, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 3, 16'h1234, 8'h00));
    // B alone, leaving lastGrant=B
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 6, 16'h6666, 0, 0, 0, 0,   0, 1, 0, 0, 1, 6, 16'h6666, 8'h00));
    // round-robin contention: A,B,A,B back-to-back
    vecs.push_back(mk(1, 1, 1, 16'hA001, 1, 4, 16'hB001, 0, 0, 0, 0,   1, 0, 0, 0, 1, 1, 16'hA001, 8'h00));
    vecs.push_back(mk(1, 1, 2, 16'hA002, 1, 4, 16'hB001, 0, 0, 0, 0,   0, 1, 0, 0, 1, 4, 16'hB001, 8'h00));
    vecs.push_back(mk(1, 1, 2, 16'hA002, 1, 5, 16'hB002, 0, 0, 0, 0,   1, 0, 0, 0, 1, 2, 16'hA002, 8'h00));
    vecs.push_back(mk(1, 1, 3, 16'hA003, 1, 5, 16'hB002, 0, 0, 0, 0,   0, 1, 0, 0, 1, 5, 16'hB002, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 5, 16'hB002, 8'h00));
    // scoreboard: reserve 5, hazard, write clears it
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 5, 0,   0, 0, 0, 0, 0, 5, 16'hB002, 8'h20));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 5, 16'h5555, 0, 0, 5, 0,   0, 1, 1, 0, 1, 5, 16'h5555, 8'h20));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 5,   0, 0, 0, 0, 0, 5, 16'h5555, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 0,   0, 0, 0, 0, 0, 5, 16'h5555, 8'h00));
    // reservation in the same edge as the clearing write: set wins
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 0, 0,   0, 0, 0, 0, 0, 5, 16'h5555, 8'h20));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 1, 5, 16'h5A5A, 0, 0, 0, 5,   0, 1, 0, 1, 1, 5, 16'h5A5A, 8'h20));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 5, 5, 2,   0, 0, 0, 0, 0, 5, 16'h5A5A, 8'h20));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 0,   0, 0, 1, 0, 0, 5, 16'h5A5A, 8'h20));
    // second pending bit, hazard2 path, clearing one bit of two
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 2, 0, 2,   0, 0, 0, 0, 0, 5, 16'h5A5A, 8'h24));
    vecs.push_back(mk(1, 1, 2, 16'h2222, 0, 0, 16'h0000, 0, 0, 0, 2,   1, 0, 0, 1, 1, 2, 16'h2222, 8'h24));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 5, 2,   0, 0, 1, 0, 0, 2, 16'h2222, 8'h20));
    // reset mid-write: dropped, then re-granted exactly once
    vecs.push_back(mk(0, 1, 7, 16'h7777, 0, 0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 16'h0000, 8'h00));
    vecs.push_back(mk(1, 1, 7, 16'h7777, 0, 0, 16'h0000, 0, 0, 0, 0,   1, 0, 0, 0, 1, 7, 16'h7777, 8'h00));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0, 0,   0, 0, 0, 0, 0, 7, 16'h7777, 8'h00));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rstN, vecs[i].aV, vecs[i].aA, vecs[i].aD, vecs[i].bV, vecs[i].bA, vecs[i].bD,
            vecs[i].rV, vecs[i].rA, vecs[i].r1, vecs[i].r2);
      #1;
      chk("aReady",  i, aReady,  vecs[i].eAR);
      chk("bReady",  i, bReady,  vecs[i].eBR);
      chk("hazard1", i, hazard1, vecs[i].eH1);
      chk("hazard2", i, hazard2, vecs[i].eH2);
      @(posedge clk);
      #1;
      chk("writeOrder",  i, writeOrder,  vecs[i].eWO);
      chk("writeAddr",   i, writeAddr,   vecs[i].eWA);
      chk("writeData",   i, writeData,   vecs[i].eWD);
      chk("pendingMask", i, pendingMask, vecs[i].ePM);
    end

    // Fixed priority instance: A wins three contended cycles, B waits
    for (int c = 0; c < 3; c++) begin
      logic [2:0]  expA;
      logic [15:0] expD;
      expA = 3'(c + 1);
      expD = 16'hF000 + 16'(c);
      @(negedge clk);
      drive(1'b1, 1'b1, expA, expD, 1'b1, 3'd6, 16'hB6B6, 1'b0, 3'd0, 3'd0, 3'd0);
      #1;
      chk("fix_aReady", c, fAReady, 1'b1);
      chk("fix_bReady", c, fBReady, 1'b0);
      @(posedge clk);
      #1;
      chk("fix_writeOrder", c, fWriteOrder, 1'b1);
      chk("fix_writeAddr",  c, fWriteAddr,  expA);
      chk("fix_writeData",  c, fWriteData,  expD);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 16'hB6B6, 1'b0, 3'd0, 3'd0, 3'd0);
    #1;
    chk("fix_bReady_after", 0, fBReady, 1'b1);
    @(posedge clk);
    #1;
    chk("fix_bWriteAddr", 0, fWriteAddr, 3'd6);
    chk("fix_bWriteData", 0, fWriteData, 16'hB6B6);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 3'd0);
    @(posedge clk);
    #1;
    chk("fix_idle_writeOrder", 0, fWriteOrder, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
